// File: rtl/acc_dvd_pkg.sv
// Shared types and elaboration helpers for the acc_dvd_param divider accelerator.
package acc_dvd_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    // Width of a counter that indexes all 2*DATA_W/BUS_W beats of one transfer phase.
    function automatic int beat_cnt_w(input int data_w, input int bus_w);
        return (2 * data_w / bus_w > 1) ? $clog2(2 * data_w / bus_w) : 1;
    endfunction

    function automatic bit widths_ok(input int data_w, input int bus_w);
        return (bus_w > 0) && (data_w >= bus_w) && (data_w % bus_w == 0);
    endfunction

endpackage

// File: rtl/acc_dvd_param_core.sv
// div_core_seq: unsigned restoring divider, one quotient bit per cycle for DATA_W cycles after start_i.
module div_core_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(DATA_W - 1);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [SW-1:0]     step_q, step_d;
    logic              run_q, run_d;
    logic [DATA_W:0]   shifted;
    logic              fits;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        step_d  = step_q;
        run_d   = run_q;
        // Partial remainder widened by one bit so the shifted value never overflows before the compare.
        shifted = {rem_q, quo_q[DATA_W-1]};
        fits    = shifted >= {1'b0, dvs_q};

        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            step_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            rem_d  = fits ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
            quo_d  = (quo_q << 1) | DATA_W'(fits);
            step_d = step_q + 1'b1;
            if (step_q == LAST_STEP) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            step_q <= step_d;
            run_q  <= run_d;
        end
    end

    assign done_o      = run_q && (step_q == LAST_STEP);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/acc_dvd_param.sv
// acc_dvd_param: streaming divide coprocessor (operands in, quotient+remainder out over BUS_W beats).
// Defining ACC_DVD_SIGNED_EN adds the signed_mode port for two's-complement division.
module acc_dvd_param
    import acc_dvd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             div_by_zero
`ifdef ACC_DVD_SIGNED_EN
    ,
    input  logic             signed_mode
`endif
);

    localparam int NB     = DATA_W / BUS_W;
    localparam int NBEATS = 2 * NB;
    localparam int CW     = beat_cnt_w(DATA_W, BUS_W);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
    localparam bit WIDTHS_OK = widths_ok(DATA_W, BUS_W);

    if (!WIDTHS_OK) begin : g_bad_width
        $error("acc_dvd_param: DATA_W must be a non-zero multiple of BUS_W");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] opnd_q, opnd_d, opnd_shift;
    logic                dbz_q, dbz_d;
    logic                sgn_mode;
    logic                core_start, core_done;
    logic [DATA_W-1:0]   core_quo, core_rem;
    logic [DATA_W-1:0]   load_dvd, load_dvs, dvd_mag, dvs_mag;
    logic [DATA_W-1:0]   held_dvd, held_dvs, res_quo, res_rem;
    logic [2*DATA_W-1:0] result;
    logic [BUS_W-1:0]    beat_sel;

`ifdef ACC_DVD_SIGNED_EN
    logic sgn_q, sgn_d;

    always_comb begin
        sgn_d = sgn_q;
        if (state_q == LOAD && in_valid && cnt_q == '0) begin
            sgn_d = signed_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sgn_q <= 1'b0;
        else     sgn_q <= sgn_d;
    end

    assign sgn_mode = sgn_q;
`else
    assign sgn_mode = 1'b0;
`endif

    // Operands as they will stand once the current beat is shifted in; used on the final load beat.
    assign opnd_shift = {opnd_q[2*DATA_W-BUS_W-1:0], in_data};
    assign load_dvd   = opnd_shift[2*DATA_W-1:DATA_W];
    assign load_dvs   = opnd_shift[DATA_W-1:0];
    assign dvd_mag    = (sgn_mode && load_dvd[DATA_W-1]) ? -load_dvd : load_dvd;
    assign dvs_mag    = (sgn_mode && load_dvs[DATA_W-1]) ? -load_dvs : load_dvs;

    div_core_seq #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (core_start),
        .dividend_i  (dvd_mag),
        .divisor_i   (dvs_mag),
        .done_o      (core_done),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    // Operand register stays intact until the next load, so signs and the zero-divisor dividend come from it.
    assign held_dvd = opnd_q[2*DATA_W-1:DATA_W];
    assign held_dvs = opnd_q[DATA_W-1:0];
    assign res_quo  = (sgn_mode && (held_dvd[DATA_W-1] ^ held_dvs[DATA_W-1])) ? -core_quo : core_quo;
    assign res_rem  = (sgn_mode && held_dvd[DATA_W-1]) ? -core_rem : core_rem;
    assign result   = dbz_q ? {{DATA_W{1'b1}}, held_dvd} : {res_quo, res_rem};

    always_comb begin
        beat_sel = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (cnt_q == CW'(NBEATS - 1 - i)) begin
                beat_sel = result[i*BUS_W +: BUS_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        dbz_d      = dbz_q;
        core_start = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    opnd_d = opnd_shift;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (load_dvs == '0) begin
                            state_d = SEND;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d    = CALC;
                            core_start = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CALC: begin
                if (core_done) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            opnd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs are forced to their idle values while rst is held, regardless of the registered state.
    assign in_ready    = !rst && (state_q == LOAD);
    assign out_valid   = !rst && (state_q == SEND);
    assign out_data    = out_valid ? beat_sel : '0;
    assign out_last    = out_valid && (cnt_q == LAST_BEAT);
    assign busy        = !rst && (state_q != LOAD);
    assign div_by_zero = !rst && dbz_q;

endmodule
